// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Trap sequencer for a simple in-order core. It looks for synchronous
// exceptions (misaligned load/store, ebreak, ecall, illegal instruction) and
// level-sensitive external interrupts, and presents one prioritised trap at a
// time to the CSR unit. It raises a one-cycle pipeline flush and tracks
// handler execution until mret.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   instr        decode-stage instruction; opcode and funct3[1:0] are
//                registered so they line up with the execute-stage address
//   ex_pc        PC of the instruction in execute
//   addr_lo      low two bits of the execute-stage load/store address
//   is_ecall, is_ebreak, is_illegal, is_mret   decode-stage class flags
//   irq, irq_en  interrupt request lines and per-line enables
//   gie          global interrupt enable
//   trap_ack     CSR unit accepts the presented trap
//   trap_valid   trap presented (held until trap_ack)
//   trap_is_irq  1 = interrupt, 0 = exception
//   trap_cause   cause code
//   trap_epc     PC to save in mepc
//   flush        one-cycle flush pulse when a trap is taken
//   in_handler   high while the trap handler is running
//   double_fault sticky flag: exception raised inside the handler
// -----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int XLEN    = 32,
    parameter int N_IRQ   = 4,
    parameter int CAUSE_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic [XLEN-1:0]    ex_pc,
    input  logic [1:0]         addr_lo,
    input  logic               is_ecall,
    input  logic               is_ebreak,
    input  logic               is_illegal,
    input  logic               is_mret,
    input  logic [N_IRQ-1:0]   irq,
    input  logic [N_IRQ-1:0]   irq_en,
    input  logic               gie,
    input  logic               trap_ack,
    output logic               trap_valid,
    output logic               trap_is_irq,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic [XLEN-1:0]    trap_epc,
    output logic               flush,
    output logic               in_handler,
    output logic               double_fault
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [CAUSE_W-1:0] CAUSE_ST_MIS  = CAUSE_W'(5'd6);
    localparam logic [CAUSE_W-1:0] CAUSE_LD_MIS  = CAUSE_W'(5'd4);
    localparam logic [CAUSE_W-1:0] CAUSE_EBREAK  = CAUSE_W'(5'd3);
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL   = CAUSE_W'(5'd11);
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = CAUSE_W'(5'd2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    // Word access needs addr_lo == 00, halfword needs addr_lo[0] == 0.
    // Byte and doubleword-encoded funct3 values never report misalignment.
    function automatic logic misaligned_f(input logic [6:0] op,
                                          input logic [1:0] f3,
                                          input logic [1:0] lo);
        logic is_mem;
        logic bad;
        is_mem = (op == OPC_LOAD) || (op == OPC_STORE);
        case (f3)
            2'b10:   bad = (lo != 2'b00);
            2'b01:   bad = lo[0];
            default: bad = 1'b0;
        endcase
        return is_mem && bad;
    endfunction

    // Index of the lowest set bit; scanning downward lets the lowest win.
    function automatic logic [4:0] lowest_idx_f(input logic [N_IRQ-1:0] p);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (p[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t               state_q;
    logic [6:0]           op_q;
    logic [1:0]           f3_q;
    logic                 trap_valid_q;
    logic                 trap_is_irq_q;
    logic [CAUSE_W-1:0]   trap_cause_q;
    logic [XLEN-1:0]      trap_epc_q;
    logic                 flush_q;
    logic                 in_handler_q;
    logic                 double_fault_q;

    logic                 mis_s;
    logic                 exc_valid_s;
    logic [CAUSE_W-1:0]   exc_cause_s;
    logic [N_IRQ-1:0]     irq_pend_s;
    logic                 irq_hit_s;
    logic [4:0]           irq_idx_s;
    logic [CAUSE_W-1:0]   irq_cause_s;
    logic                 instr_unused_s;

    // Only opcode and funct3[1:0] of the decode instruction matter here.
    assign instr_unused_s = ^{instr[31:14], instr[11:7]};

    // Misalignment uses the opcode registered last cycle against this cycle's address.
    assign mis_s = misaligned_f(op_q, f3_q, addr_lo);

    // Exception priority: misaligned > ebreak > ecall > illegal.
    always_comb begin
        exc_valid_s = 1'b1;
        exc_cause_s = {CAUSE_W{1'b0}};
        if (mis_s) begin
            exc_cause_s = (op_q == OPC_STORE) ? CAUSE_ST_MIS : CAUSE_LD_MIS;
        end else if (is_ebreak) begin
            exc_cause_s = CAUSE_EBREAK;
        end else if (is_ecall) begin
            exc_cause_s = CAUSE_ECALL;
        end else if (is_illegal) begin
            exc_cause_s = CAUSE_ILLEGAL;
        end else begin
            exc_valid_s = 1'b0;
        end
    end

    // Interrupt selection: enabled, globally gated, lowest line first.
    always_comb begin
        irq_pend_s  = irq & irq_en & {N_IRQ{gie}};
        irq_hit_s   = |irq_pend_s;
        irq_idx_s   = lowest_idx_f(irq_pend_s);
        irq_cause_s = CAUSE_W'(5'd16 + irq_idx_s);
    end

    // Trap FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            op_q           <= 7'd0;
            f3_q           <= 2'd0;
            trap_valid_q   <= 1'b0;
            trap_is_irq_q  <= 1'b0;
            trap_cause_q   <= {CAUSE_W{1'b0}};
            trap_epc_q     <= {XLEN{1'b0}};
            flush_q        <= 1'b0;
            in_handler_q   <= 1'b0;
            double_fault_q <= 1'b0;
        end else begin
            op_q    <= instr[6:0];
            f3_q    <= instr[13:12];
            flush_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Exceptions beat interrupts; a losing interrupt stays
                    // pending because irq is level-sensitive.
                    if (exc_valid_s) begin
                        state_q       <= ST_REQ;
                        trap_valid_q  <= 1'b1;
                        trap_is_irq_q <= 1'b0;
                        trap_cause_q  <= exc_cause_s;
                        trap_epc_q    <= ex_pc;
                        flush_q       <= 1'b1;
                    end else if (irq_hit_s) begin
                        state_q       <= ST_REQ;
                        trap_valid_q  <= 1'b1;
                        trap_is_irq_q <= 1'b1;
                        trap_cause_q  <= irq_cause_s;
                        trap_epc_q    <= ex_pc;
                        flush_q       <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Payload frozen until the CSR unit takes it.
                    if (trap_ack) begin
                        state_q      <= ST_HANDLER;
                        trap_valid_q <= 1'b0;
                        in_handler_q <= 1'b1;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_HANDLER: begin
                    // Interrupts are masked here; an exception wins over mret.
                    if (exc_valid_s) begin
                        double_fault_q <= 1'b1;
                    end else if (is_mret) begin
                        state_q      <= ST_IDLE;
                        in_handler_q <= 1'b0;
                    end else begin
                        state_q <= ST_HANDLER;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    trap_valid_q <= 1'b0;
                    in_handler_q <= 1'b0;
                end
            endcase
        end
    end

    assign trap_valid   = trap_valid_q;
    assign trap_is_irq  = trap_is_irq_q;
    assign trap_cause   = trap_cause_q;
    assign trap_epc     = trap_epc_q;
    assign flush        = flush_q;
    assign in_handler   = in_handler_q;
    assign double_fault = double_fault_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
    localparam int XLEN    = 32;
    localparam int N_IRQ   = 4;
    localparam int CAUSE_W = 5;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_ALU   = 7'b0110011;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        instr;
    logic [XLEN-1:0]    ex_pc;
    logic [1:0]         addr_lo;
    logic               is_ecall, is_ebreak, is_illegal, is_mret;
    logic [N_IRQ-1:0]   irq, irq_en;
    logic               gie;
    logic               trap_ack;
    logic               trap_valid, trap_is_irq, flush, in_handler, double_fault;
    logic [CAUSE_W-1:0] trap_cause;
    logic [XLEN-1:0]    trap_epc;

    typedef struct packed {
        logic               is_irq;
        logic [CAUSE_W-1:0] cause;
        logic [XLEN-1:0]    epc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    trap_ctrl #(.XLEN(XLEN), .N_IRQ(N_IRQ), .CAUSE_W(CAUSE_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .ex_pc(ex_pc), .addr_lo(addr_lo),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_illegal(is_illegal),
        .is_mret(is_mret), .irq(irq), .irq_en(irq_en), .gie(gie),
        .trap_ack(trap_ack), .trap_valid(trap_valid), .trap_is_irq(trap_is_irq),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .flush(flush),
        .in_handler(in_handler), .double_fault(double_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard consumer: every flush pulse must match the oldest expected trap.
    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_trap: got irq=%0b cause=%0d epc=%h, expected no trap",
                         trap_is_irq, trap_cause, trap_epc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({trap_valid, trap_is_irq, trap_cause, trap_epc} !==
                    {1'b1, mon_e.is_irq, mon_e.cause, mon_e.epc}) begin
                    failures++;
                    $display("FAIL trap_payload: got v=%0b irq=%0b cause=%0d epc=%h, expected v=1 irq=%0b cause=%0d epc=%h",
                             trap_valid, trap_is_irq, trap_cause, trap_epc,
                             mon_e.is_irq, mon_e.cause, mon_e.epc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_i, input logic [CAUSE_W-1:0] c, input logic [XLEN-1:0] pc);
        exp_t e;
        e.is_irq = is_i;
        e.cause  = c;
        e.epc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        instr = NOP; ex_pc = 32'h0; addr_lo = 2'b00;
        is_ecall = 1'b0; is_ebreak = 1'b0; is_illegal = 1'b0; is_mret = 1'b0;
        irq = 4'b0000; irq_en = 4'b1111; gie = 1'b1; trap_ack = 1'b0;
    endtask

    task automatic set_mem(input logic [6:0] op, input logic [2:0] f3);
        instr = {17'b0, f3, 5'b0, op};
    endtask

    // Acknowledge the pending trap and return from the handler.
    task automatic finish_trap();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        is_mret = 1'b1;
        step();
        is_mret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({trap_valid, trap_is_irq, flush, in_handler, double_fault, trap_cause, trap_epc} !== 39'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%0b irq=%0b fl=%0b ih=%0b df=%0b c=%0d epc=%h, expected all 0",
                     trap_valid, trap_is_irq, flush, in_handler, double_fault, trap_cause, trap_epc);
        end
        is_ecall = 1'b1;
        step();
        checks++;
        if (trap_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got trap_valid=%0b, expected 0", trap_valid);
        end
        is_ecall = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_misaligned();
        set_mem(OP_LOAD, 3'b010);
        step();
        instr = NOP; addr_lo = 2'b10; ex_pc = 32'h0000_0104;
        push(1'b0, 5'd4, 32'h0000_0104);
        step();
        addr_lo = 2'b00;
        checks++;
        if ({trap_valid, trap_is_irq, trap_cause, flush} !== {1'b1, 1'b0, 5'd4, 1'b1}) begin
            failures++;
            $display("FAIL lw_mis_first: got v=%0b irq=%0b cause=%0d flush=%0b, expected 1 0 4 1",
                     trap_valid, trap_is_irq, trap_cause, flush);
        end
        step();
        checks++;
        if ({trap_valid, flush} !== 2'b10) begin
            failures++;
            $display("FAIL lw_mis_second: got v=%0b flush=%0b, expected v=1 flush=0", trap_valid, flush);
        end
        finish_trap();
    endtask

    task automatic one_mem(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [1:0] lo, input logic exp_trap, input logic [4:0] cause);
        set_mem(op, f3);
        step();
        instr = NOP; addr_lo = lo; ex_pc = {24'h0, 1'b1, f3, 2'b00, lo};
        if (exp_trap) push(1'b0, cause, {24'h0, 1'b1, f3, 2'b00, lo});
        step();
        addr_lo = 2'b00;
        checks++;
        if (trap_valid !== exp_trap || (exp_trap && trap_cause !== cause)) begin
            failures++;
            $display("FAIL %s: got v=%0b cause=%0d, expected v=%0b cause=%0d",
                     name, trap_valid, trap_cause, exp_trap, cause);
        end
        if (exp_trap) finish_trap();
    endtask

    task automatic test_mem_sizes();
        one_mem("sw_lo01",  OP_STORE, 3'b010, 2'b01, 1'b1, 5'd6);
        one_mem("lh_lo01",  OP_LOAD,  3'b001, 2'b01, 1'b1, 5'd4);
        one_mem("sh_lo11",  OP_STORE, 3'b001, 2'b11, 1'b1, 5'd6);
        one_mem("lhu_lo11", OP_LOAD,  3'b101, 2'b11, 1'b1, 5'd4);
        one_mem("lwu_lo10", OP_LOAD,  3'b110, 2'b10, 1'b1, 5'd4);
        one_mem("lh_lo10",  OP_LOAD,  3'b001, 2'b10, 1'b0, 5'd0);
        one_mem("lb_lo11",  OP_LOAD,  3'b000, 2'b11, 1'b0, 5'd0);
        one_mem("ld_lo01",  OP_LOAD,  3'b011, 2'b01, 1'b0, 5'd0);
        one_mem("sw_lo00",  OP_STORE, 3'b010, 2'b00, 1'b0, 5'd0);
        one_mem("alu_lo11", OP_ALU,   3'b010, 2'b11, 1'b0, 5'd0);
    endtask

    task automatic one_exc(input string name, input logic mis, input logic eb, input logic ec,
                           input logic il, input logic [4:0] cause);
        if (mis) begin
            set_mem(OP_LOAD, 3'b010);
            step();
        end
        instr = NOP; addr_lo = mis ? 2'b11 : 2'b00;
        is_ebreak = eb; is_ecall = ec; is_illegal = il;
        irq = 4'b0001; ex_pc = {27'h0, cause};
        push(1'b0, cause, {27'h0, cause});
        step();
        is_ebreak = 1'b0; is_ecall = 1'b0; is_illegal = 1'b0; addr_lo = 2'b00; irq = 4'b0000;
        checks++;
        if ({trap_valid, trap_is_irq, trap_cause} !== {1'b1, 1'b0, cause}) begin
            failures++;
            $display("FAIL %s: got v=%0b irq=%0b cause=%0d, expected v=1 irq=0 cause=%0d",
                     name, trap_valid, trap_is_irq, trap_cause, cause);
        end
        finish_trap();
    endtask

    task automatic test_priority();
        one_exc("prio_all",     1'b1, 1'b1, 1'b1, 1'b1, 5'd4);
        one_exc("prio_ebreak",  1'b0, 1'b1, 1'b1, 1'b1, 5'd3);
        one_exc("prio_ecall",   1'b0, 1'b0, 1'b1, 1'b1, 5'd11);
        one_exc("prio_illegal", 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
    endtask

    task automatic test_exc_vs_irq();
        irq_en = 4'b1111; gie = 1'b1; irq = 4'b0100;
        is_ecall = 1'b1; ex_pc = 32'h200;
        push(1'b0, 5'd11, 32'h200);
        step();
        is_ecall = 1'b0;
        checks++;
        if ({trap_valid, trap_is_irq, trap_cause} !== {1'b1, 1'b0, 5'd11}) begin
            failures++;
            $display("FAIL exc_beats_irq: got v=%0b irq=%0b cause=%0d, expected 1 0 11",
                     trap_valid, trap_is_irq, trap_cause);
        end
        step();
        checks++;
        if ({trap_valid, trap_is_irq, trap_cause} !== {1'b1, 1'b0, 5'd11}) begin
            failures++;
            $display("FAIL req_ignores_irq: got v=%0b irq=%0b cause=%0d, expected 1 0 11",
                     trap_valid, trap_is_irq, trap_cause);
        end
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        step();
        checks++;
        if ({in_handler, trap_valid} !== 2'b10) begin
            failures++;
            $display("FAIL handler_masks_irq: got ih=%0b v=%0b, expected ih=1 v=0", in_handler, trap_valid);
        end
        is_mret = 1'b1; ex_pc = 32'h300;
        push(1'b1, 5'd18, 32'h300);
        step();
        is_mret = 1'b0;
        step();
        checks++;
        if ({trap_valid, trap_is_irq, trap_cause, in_handler} !== {1'b1, 1'b1, 5'd18, 1'b0}) begin
            failures++;
            $display("FAIL irq_after_mret: got v=%0b irq=%0b cause=%0d ih=%0b, expected 1 1 18 0",
                     trap_valid, trap_is_irq, trap_cause, in_handler);
        end
        irq = 4'b0000;
        finish_trap();
    endtask

    task automatic test_irq_mask();
        irq = 4'b0110; irq_en = 4'b0100; gie = 1'b1; ex_pc = 32'h500;
        push(1'b1, 5'd18, 32'h500);
        step();
        irq = 4'b0000;
        checks++;
        if ({trap_valid, trap_cause} !== {1'b1, 5'd18}) begin
            failures++;
            $display("FAIL irq_enable_mask: got v=%0b cause=%0d, expected v=1 cause=18", trap_valid, trap_cause);
        end
        finish_trap();
        irq = 4'b1010; irq_en = 4'b1111; ex_pc = 32'h504;
        push(1'b1, 5'd17, 32'h504);
        step();
        irq = 4'b0000;
        checks++;
        if ({trap_valid, trap_cause} !== {1'b1, 5'd17}) begin
            failures++;
            $display("FAIL irq_lowest_wins: got v=%0b cause=%0d, expected v=1 cause=17", trap_valid, trap_cause);
        end
        finish_trap();
        gie = 1'b0; irq = 4'b0110; irq_en = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (trap_valid !== 1'b0) begin
                failures++;
                $display("FAIL irq_gie_off: got v=%0b, expected 0", trap_valid);
            end
        end
        irq = 4'b0000; irq_en = 4'b1111; gie = 1'b1;
    endtask

    task automatic test_req_hold();
        is_illegal = 1'b1; ex_pc = 32'h400;
        push(1'b0, 5'd2, 32'h400);
        step();
        for (int i = 0; i < 5; i++) begin
            is_illegal = ~is_illegal;
            ex_pc = 32'h900 + 32'(i * 4);
            irq = 4'b0001;
            step();
            checks++;
            if ({trap_valid, trap_is_irq, trap_cause, trap_epc, flush} !== {1'b1, 1'b0, 5'd2, 32'h400, 1'b0}) begin
                failures++;
                $display("FAIL req_hold: got v=%0b irq=%0b cause=%0d epc=%h flush=%0b, expected 1 0 2 00000400 0",
                         trap_valid, trap_is_irq, trap_cause, trap_epc, flush);
            end
        end
        is_illegal = 1'b0; irq = 4'b0000;
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        checks++;
        if ({in_handler, trap_valid} !== 2'b10) begin
            failures++;
            $display("FAIL ack_to_handler: got ih=%0b v=%0b, expected ih=1 v=0", in_handler, trap_valid);
        end
        is_mret = 1'b1;
        step();
        is_mret = 1'b0;
        checks++;
        if (in_handler !== 1'b0) begin
            failures++;
            $display("FAIL mret_exit: got ih=%0b, expected 0", in_handler);
        end
    endtask

    task automatic test_ignored_controls();
        is_mret = 1'b1; trap_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({trap_valid, in_handler, flush} !== 3'b000) begin
                failures++;
                $display("FAIL idle_ignores_mret_ack: got v=%0b ih=%0b fl=%0b, expected 000",
                         trap_valid, in_handler, flush);
            end
        end
        is_mret = 1'b0; trap_ack = 1'b0;
        is_ecall = 1'b1; ex_pc = 32'h600;
        push(1'b0, 5'd11, 32'h600);
        step();
        is_ecall = 1'b0; trap_ack = 1'b1;
        step();
        step();
        checks++;
        if ({in_handler, trap_valid} !== 2'b10) begin
            failures++;
            $display("FAIL handler_ignores_ack: got ih=%0b v=%0b, expected ih=1 v=0", in_handler, trap_valid);
        end
        trap_ack = 1'b0; is_mret = 1'b1;
        step();
        is_mret = 1'b0;
    endtask

    task automatic test_double_fault();
        is_ecall = 1'b1; ex_pc = 32'h700;
        push(1'b0, 5'd11, 32'h700);
        step();
        is_ecall = 1'b0; trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        is_illegal = 1'b1; is_mret = 1'b1;
        step();
        is_illegal = 1'b0; is_mret = 1'b0;
        checks++;
        if ({double_fault, in_handler, trap_valid, flush} !== 4'b1100) begin
            failures++;
            $display("FAIL double_fault_set: got df=%0b ih=%0b v=%0b fl=%0b, expected 1 1 0 0",
                     double_fault, in_handler, trap_valid, flush);
        end
        step();
        checks++;
        if ({double_fault, in_handler} !== 2'b11) begin
            failures++;
            $display("FAIL double_fault_sticky: got df=%0b ih=%0b, expected 1 1", double_fault, in_handler);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({trap_valid, trap_is_irq, flush, in_handler, double_fault, trap_cause, trap_epc} !== 39'd0) begin
            failures++;
            $display("FAIL df_reset_clear: got v=%0b irq=%0b fl=%0b ih=%0b df=%0b c=%0d epc=%h, expected all 0",
                     trap_valid, trap_is_irq, flush, in_handler, double_fault, trap_cause, trap_epc);
        end
        rst = 1'b0;
        is_ebreak = 1'b1; ex_pc = 32'h710;
        push(1'b0, 5'd3, 32'h710);
        step();
        is_ebreak = 1'b0;
        checks++;
        if ({trap_valid, trap_cause, double_fault} !== {1'b1, 5'd3, 1'b0}) begin
            failures++;
            $display("FAIL trap_after_reset: got v=%0b cause=%0d df=%0b, expected 1 3 0",
                     trap_valid, trap_cause, double_fault);
        end
        finish_trap();
    endtask

    task automatic test_async_reset();
        is_ecall = 1'b1; ex_pc = 32'h7f0;
        push(1'b0, 5'd11, 32'h7f0);
        step();
        is_ecall = 1'b0;
        checks++;
        if (trap_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_setup: got v=%0b, expected 1", trap_valid);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({trap_valid, flush, trap_cause, trap_epc} !== 39'd0) begin
            failures++;
            $display("FAIL async_reset: got v=%0b fl=%0b cause=%0d epc=%h, expected all 0",
                     trap_valid, flush, trap_cause, trap_epc);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({trap_valid, in_handler} !== 2'b00) begin
                failures++;
                $display("FAIL async_no_residual: got v=%0b ih=%0b, expected 0 0", trap_valid, in_handler);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_misaligned();
        test_mem_sizes();
        test_priority();
        test_exc_vs_irq();
        test_irq_mask();
        test_req_hold();
        test_ignored_controls();
        test_double_fault();
        test_async_reset();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_traps: got %0d unconsumed expected traps, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
